// File: rtl/adam_aes_pkg.sv
// adam_aes_pkg
// Shared types and constants for the AES key schedule:
//   keylen_e - encoding of the keylen port
//   NK_/NR_/NW_ constants per key length, plus nk_of/nr_of/nw_of helpers
//   xtime    - GF(2^8) multiply-by-two used to advance rcon
//   state_e  - key expansion FSM states
package adam_aes_pkg;

  typedef enum logic [1:0] {
    KEYLEN_128 = 2'b00,
    KEYLEN_192 = 2'b01,
    KEYLEN_256 = 2'b10,
    KEYLEN_BAD = 2'b11
  } keylen_e;

  localparam int NK_128 = 4;
  localparam int NK_192 = 6;
  localparam int NK_256 = 8;

  localparam int NR_128 = NK_128 + 6;
  localparam int NR_192 = NK_192 + 6;
  localparam int NR_256 = NK_256 + 6;

  localparam int NW_128 = 4 * (NR_128 + 1);
  localparam int NW_192 = 4 * (NR_192 + 1);
  localparam int NW_256 = 4 * (NR_256 + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic int nk_of(input keylen_e kl);
    case (kl)
      KEYLEN_192: return NK_192;
      KEYLEN_256: return NK_256;
      default:    return NK_128;
    endcase
  endfunction

  function automatic int nr_of(input keylen_e kl);
    return nk_of(kl) + 6;
  endfunction

  function automatic int nw_of(input keylen_e kl);
    return 4 * (nr_of(kl) + 1);
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/adam_aes_key_word_mem.sv
// adam_aes_key_word_mem
// Expanded-key word store, NW_MAX x 32 bits, cleared by reset.
//   clk, reset_n          - clock, asynchronous active-low reset
//   we, waddr, wdata      - single write port
//   raddr_a / rdata_a     - combinational word read (used for w[i-1])
//   raddr_b / rdata_b     - combinational word read (used for w[i-Nk])
//   round / round_words   - combinational read of words 4*round..4*round+3,
//                           word 4*round in the top 32 bits
// Addresses beyond NW_MAX-1 read as zero and writes to them are dropped.
module adam_aes_key_word_mem #(
  parameter int NW_MAX = 60,
  parameter int AW     = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   rdata_b,
  input  logic [3:0]    round,
  output logic [127:0]  round_words
);

  logic [31:0] mem [NW_MAX];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '{default: '0};
    end else if (we && (int'(waddr) < NW_MAX)) begin
      mem[waddr] <= wdata;
    end
  end

  // Range-checked word select; the round port can address past NW_MAX.
  function automatic logic [31:0] pick(input int idx);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < NW_MAX; j++) begin
      if (j == idx) r = mem[AW'(j)];
    end
    return r;
  endfunction

  assign rdata_a = pick(int'(raddr_a));
  assign rdata_b = pick(int'(raddr_b));

  for (genvar gi = 0; gi < 4; gi++) begin : g_round_word
    assign round_words[127-32*gi -: 32] = pick(4 * int'(round) + gi);
  end

endmodule

// File: rtl/adam_aes_key_schedule.sv
// adam_aes_key_schedule
// AES key expansion for 128/192/256-bit keys into an on-chip word memory.
// One word is produced per cycle; words needing SubWord wait for an external
// S-box via sbox_req/sbox_ack (or assume a combinational S-box when SBOX_HS=0).
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   key, keylen    - MSB-aligned cipher key and its length code
//   init           - single-cycle start pulse (also aborts a running expansion)
//   round          - round-key index; round_key returns words 4*round..+3
//   ready, busy    - schedule complete / expansion in progress
//   key_err        - the last init carried an unsupported keylen
//   sboxw, sbox_req, new_sboxw, sbox_ack - external S-box handshake
// Build option: define ADAM_AES_KEY192_EN to support 192-bit keys; otherwise
// keylen 01 is rejected like keylen 11.
module adam_aes_key_schedule
  import adam_aes_pkg::*;
#(
  parameter int SBOX_HS = 1,
  parameter int NW_MAX  = 60
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] key,
  input  logic [1:0]   keylen,
  input  logic         init,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic         busy,
  output logic         key_err,
  output logic [31:0]  sboxw,
  output logic         sbox_req,
  input  logic [31:0]  new_sboxw,
  input  logic         sbox_ack
);

  localparam int AW = (NW_MAX > 8) ? $clog2(NW_MAX) : 3;

  state_e        state_reg, state_next;
  logic [255:0]  key_reg, key_next;
  keylen_e       keylen_reg, keylen_next;
  logic [AW-1:0] cnt_reg, cnt_next;
  logic [2:0]    mod_reg, mod_next;   // i mod Nk
  logic [7:0]    rcon_reg, rcon_next;
  logic          ready_reg, ready_next;
  logic          key_err_reg, key_err_next;

  int nk_cur;
  int nr_cur;
  int nw_cur;

`ifdef ADAM_AES_KEY192_EN
  assign nk_cur = nk_of(keylen_reg);

  function automatic logic keylen_ok(input logic [1:0] kl);
    return kl != KEYLEN_BAD;
  endfunction
`else
  // Only Nk = 4 or 8 can occur, so the mod-6 case never exists.
  assign nk_cur = (keylen_reg == KEYLEN_256) ? NK_256 : NK_128;

  function automatic logic keylen_ok(input logic [1:0] kl);
    return (kl == KEYLEN_128) || (kl == KEYLEN_256);
  endfunction
`endif

  assign nr_cur = nk_cur + 6;
  assign nw_cur = 4 * (nr_cur + 1);

  // Registered key split into 32-bit words, word 0 in the MSBs.
  logic [31:0] key_word [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_key_word
    assign key_word[gi] = key_reg[255-32*gi -: 32];
  end

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] addr_prev, addr_old;
  logic [31:0]   w_prev, w_old;
  logic [127:0]  mem_round;

  assign addr_prev = cnt_reg - AW'(1);
  assign addr_old  = cnt_reg - AW'(nk_cur);

  adam_aes_key_word_mem #(
    .NW_MAX (NW_MAX),
    .AW     (AW)
  ) u_mem (
    .clk         (clk),
    .reset_n     (reset_n),
    .we          (mem_we),
    .waddr       (mem_waddr),
    .wdata       (mem_wdata),
    .raddr_a     (addr_prev),
    .rdata_a     (w_prev),
    .raddr_b     (addr_old),
    .rdata_b     (w_old),
    .round       (round),
    .round_words (mem_round)
  );

  // Words at i mod Nk == 0 (and i mod 8 == 4 for 256-bit keys) need SubWord.
  logic        sbox_word;
  logic        ack_eff;
  logic [31:0] exp_word;

  assign sbox_word = (state_reg == ST_EXPAND) &&
                     ((mod_reg == 3'd0) || ((nk_cur == NK_256) && (mod_reg == 3'd4)));
  assign ack_eff   = (SBOX_HS != 0) ? sbox_ack : 1'b1;
  assign sbox_req  = sbox_word;
  assign sboxw     = sbox_word ? w_prev : 32'h0;

  // RotWord(SubWord(x)) equals SubWord(RotWord(x)), so the substituted word
  // from the S-box is simply rotated left one byte here.
  always_comb begin
    exp_word = w_old ^ w_prev;
    if (mod_reg == 3'd0) begin
      exp_word = w_old ^ {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_reg, 24'h0};
    end else if ((nk_cur == NK_256) && (mod_reg == 3'd4)) begin
      exp_word = w_old ^ new_sboxw;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_reg     <= '0;
      keylen_reg  <= KEYLEN_128;
      cnt_reg     <= '0;
      mod_reg     <= '0;
      rcon_reg    <= '0;
      ready_reg   <= 1'b0;
      key_err_reg <= 1'b0;
    end else begin
      key_reg     <= key_next;
      keylen_reg  <= keylen_next;
      cnt_reg     <= cnt_next;
      mod_reg     <= mod_next;
      rcon_reg    <= rcon_next;
      ready_reg   <= ready_next;
      key_err_reg <= key_err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    key_next     = key_reg;
    keylen_next  = keylen_reg;
    cnt_next     = cnt_reg;
    mod_next     = mod_reg;
    rcon_next    = rcon_reg;
    ready_next   = ready_reg;
    key_err_next = key_err_reg;
    mem_we       = 1'b0;
    mem_waddr    = cnt_reg;
    mem_wdata    = 32'h0;

    case (state_reg)
      ST_IDLE: begin
      end
      ST_LOAD: begin
        mem_we    = 1'b1;
        mem_wdata = key_word[cnt_reg[2:0]];
        cnt_next  = cnt_reg + AW'(1);
        if (int'(cnt_reg) == nk_cur - 1) begin
          state_next = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        // An S-box word stalls here until its substitution is acknowledged.
        if (!sbox_word || ack_eff) begin
          mem_we    = 1'b1;
          mem_wdata = exp_word;
          cnt_next  = cnt_reg + AW'(1);
          mod_next  = (int'(mod_reg) == nk_cur - 1) ? 3'd0 : mod_reg + 3'd1;
          if (mod_reg == 3'd0) begin
            rcon_next = xtime(rcon_reg);
          end
          if (int'(cnt_reg) == nw_cur - 1) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        ready_next = 1'b1;
        cnt_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // init takes priority over everything and may abort a running expansion.
    // An invalid keylen leaves memory and the accepted keylen untouched.
    if (init) begin
      mem_we     = 1'b0;
      cnt_next   = '0;
      mod_next   = '0;
      ready_next = 1'b0;
      if (keylen_ok(keylen)) begin
        state_next   = ST_LOAD;
        key_next     = key;
        keylen_next  = keylen_e'(keylen);
        rcon_next    = 8'h01;
        key_err_next = 1'b0;
      end else begin
        state_next   = ST_IDLE;
        key_err_next = 1'b1;
      end
    end
  end

  assign ready     = ready_reg;
  assign key_err   = key_err_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign round_key = (int'(round) > nr_cur) ? 128'h0 : mem_round;

endmodule

// File: tb/tb_adam_aes_key_schedule.sv
// tb_adam_aes_key_schedule
// Directed bench for adam_aes_key_schedule: a behavioural S-box responder with
// programmable acknowledge delay, a reference key expansion that fills a
// scoreboard queue of expected round keys on each init, and checks of timing,
// abort, error and reset behaviour.
module tb_adam_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] key_in;
  logic [1:0]   keylen_in;
  logic         init;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic         busy;
  logic         key_err;
  logic [31:0]  sboxw;
  logic         sbox_req;
  logic [31:0]  new_sboxw;
  logic         sbox_ack;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  int wait_cnt = 0;

  logic [7:0]  sbox_tab [256];
  logic [31:0] mw [60];

  typedef struct packed {
    logic [3:0]   rnd;
    logic [127:0] val;
  } sb_t;
  sb_t sb [$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  adam_aes_key_schedule #(
    .SBOX_HS (1),
    .NW_MAX  (60)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key       (key_in),
    .keylen    (keylen_in),
    .init      (init),
    .round     (round),
    .round_key (round_key),
    .ready     (ready),
    .busy      (busy),
    .key_err   (key_err),
    .sboxw     (sboxw),
    .sbox_req  (sbox_req),
    .new_sboxw (new_sboxw),
    .sbox_ack  (sbox_ack)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, bb;
    for (int b = 0; b < 256; b++) begin
      bb = 8'(b);
      inv = 8'h00;
      if (b != 0) begin
        for (int c = 1; c < 256; c++) begin
          if (gmul(bb, 8'(c)) == 8'h01) inv = 8'(c);
        end
      end
      sbox_tab[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook key expansion into mw[].
  task automatic model_expand(input logic [255:0] k, input int nk);
    logic [255:0] sh;
    logic [31:0]  t;
    logic [7:0]   rc;
    int nw;
    nw = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) begin
      sh = k << (32 * i);
      mw[i] = sh[255:224];
    end
    for (int i = nk; i < nw; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  // ---------------- S-box responder ----------------
  assign new_sboxw = sub_word(sboxw);
  assign sbox_ack  = sbox_req && (wait_cnt >= ack_delay);

  always @(posedge clk) begin
    if (!sbox_req || sbox_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sboxw must not move while a request waits for its acknowledge.
  logic        hold_valid = 1'b0;
  logic [31:0] hold_word  = 32'h0;
  always @(negedge clk) begin
    if (hold_valid && sbox_req) chk("sboxw_stable", sboxw, hold_word);
    hold_valid = sbox_req && !sbox_ack;
    hold_word  = sboxw;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_init(input logic [255:0] k, input logic [1:0] kl);
    @(negedge clk);
    key_in    = k;
    keylen_in = kl;
    init      = 1'b1;
    @(posedge clk);
    #1;
    init      = 1'b0;
    key_in    = ~k;       // later port changes must not leak into the schedule
    keylen_in = ~kl;
  endtask

  task automatic start(input logic [255:0] k, input logic [1:0] kl, input int nk);
    sb_t e;
    do_init(k, kl);
    model_expand(k, nk);
    for (int r = 0; r <= nk + 6; r++) begin
      e.rnd = 4'(r);
      e.val = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
      sb.push_back(e);
    end
    if (nk + 7 <= 15) begin
      e.rnd = 4'(nk + 7);
      e.val = 128'h0;
      sb.push_back(e);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_seen", ready, 1);
  endtask

  task automatic drain(input string tag);
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      round = e.rnd;
      #1;
      chk($sformatf("%s_round%0d", tag, e.rnd), round_key, e.val);
    end
  endtask

  task automatic read_round(input logic [3:0] r);
    @(negedge clk);
    round = r;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int n;
  int seen;

  initial begin
    build_sbox();
    reset_n = 1'b0; key_in = '0; keylen_in = 2'b00; init = 1'b0; round = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_sbox_req", sbox_req, 0);
    chk("rst_sboxw", sboxw, 0);
    chk("rst_round_key", round_key, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // AES-128, acknowledge in the request cycle
    ack_delay = 0;
    start(K128, 2'b00, 4);
    chk("a128_busy", busy, 1);
    chk("a128_ready_low", ready, 0);
    wait_ready(n);
    chk("a128_latency", n, 45);
    chk("a128_busy_done", busy, 0);
    drain("a128");
    read_round(4'd10);
    chk("a128_known_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192
`ifdef ADAM_AES_KEY192_EN
    start(K192, 2'b01, 6);
    chk("a192_key_err", key_err, 0);
    wait_ready(n);
    chk("a192_latency", n, 53);
    drain("a192");
    read_round(4'd12);
    chk("a192_known_r12", round_key, 128'he98ba06f448c773c8ecc720401002202);
`else
    do_init(K192, 2'b01);
    chk("a192_key_err", key_err, 1);
    chk("a192_busy", busy, 0);
    chk("a192_ready", ready, 0);
    read_round(4'd10);
    chk("a192_mem_kept", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif

    // invalid keylen
    do_init(K256, 2'b11);
    chk("bad_key_err", key_err, 1);
    chk("bad_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_busy_later", busy, 0);

    // AES-256, acknowledge after three wait cycles: 13 S-box words x 3 extra
    ack_delay = 3;
    start(K256, 2'b10, 8);
    chk("a256_key_err_clear", key_err, 0);
    wait_ready(n);
    chk("a256_latency", n, 100);
    drain("a256");
    read_round(4'd14);
    chk("a256_known_r14", round_key, 128'hfe4890d1e6188d0b046df344706c631e);

    // Abort: AES-256 stalled on an S-box request, restarted as AES-128
    ack_delay = 3;
    do_init(K256, 2'b10);
    n = 0;
    while (sbox_req !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_req_seen", sbox_req, 1);
    sb.delete();
    start(K128, 2'b00, 4);
    chk("abort_req_drop", sbox_req, 0);
    chk("abort_busy", busy, 1);
    ack_delay = 0;
    wait_ready(n);
    chk("abort_latency", n, 45);
    drain("abort");
    read_round(4'd11);
    chk("abort_r11_zero", round_key, 0);

    // Reset mid-expansion
    do_init(K256, 2'b10);
    repeat (20) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    round   = 4'd1;
    @(posedge clk);
    #1;
    chk("midrst_ready", ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_key_err", key_err, 0);
    chk("midrst_sbox_req", sbox_req, 0);
    chk("midrst_sboxw", sboxw, 0);
    chk("midrst_round_key", round_key, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1 || busy === 1'b1) seen++;
    end
    chk("midrst_no_resume", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
